hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. It generalises load-use stall
//  detection with a configurable load latency (multi-bubble stalls) and source-used
//  qualifiers. It adds a whole-pipe freeze on a data-memory wait handshake, taken-branch
//  flush, and saturating stall/freeze/flush performance counters.
//  It sits beside the ID stage and drives the PC, IF/ID and ID/EX control, plus the freeze of all stage buffers.
// PARAMETERS
//  REG_AW    5   register-index width; index 0 is the hardwired zero register
//  LOAD_LAT  1   bubbles inserted per load-use hazard; legal range 1..8
//  CNT_W     32  width of each performance counter
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       synchronous reset, active-high
//  rs1_ID, rs2_ID   in   REG_AW  source registers of the instruction in ID
//  rs1_used_ID      in   1       instruction in ID reads rs1
//  rs2_used_ID      in   1       instruction in ID reads rs2
//  rd_EX            in   REG_AW  destination register of the instruction in EX
//  MemRead_EX       in   1       instruction in EX is a load
//  mem_req_MEM      in   1       MEM stage has an active data-memory access
//  mem_ready        in   1       data memory completes the MEM access this cycle
//  branch_taken_EX  in   1       branch/jump resolved taken in EX
//  clr_cnt          in   1       synchronous clear of all performance counters
//  PC_Write         out  1       PC update enable
//  IF_buffer_Write  out  1       IF/ID buffer write enable
//  NOP              out  1       insert bubble into ID/EX
//  flush_IF         out  1       squash IF/ID contents
//  flush_ID         out  1       squash ID/EX contents
//  pipe_freeze      out  1       hold ID/EX, EX/MEM and MEM/WB buffers
//  stall_state      out  2       FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT
//  stall_cycles     out  CNT_W   count of cycles with NOP=1
//  freeze_cycles    out  CNT_W   count of cycles with pipe_freeze=1
//  flush_count      out  CNT_W   count of cycles with flush_IF=1
// BEHAVIOUR
//  - lu_hit (comb.): MemRead_EX & (rd_EX!=0) & ((rs1_used_ID & rs1_ID==rd_EX) |
//    (rs2_used_ID & rs2_ID==rd_EX)). An unused source never causes a stall.
//  - mem_wait (comb.): mem_req_MEM & ~mem_ready.
//  - Outputs are combinational from the state and inputs. Default: PC_Write=1,
//    IF_buffer_Write=1, NOP=0, flush_*=0, pipe_freeze=0.
//  - Reset: while rst=1, all outputs take their defaults. State goes to RUN, the bubble
//    counter bcnt to 0, and all perf counters to 0. Reset mid-stall or mid-freeze aborts it.
//  - Priority in every state: mem_wait > branch_taken_EX > lu_hit.
//  - RUN:
//    - mem_wait: pipe_freeze=1, PC_Write=0, IF_buffer_Write=0. Save ret=RUN, next MEM_WAIT.
//    - else branch_taken_EX: flush_IF=flush_ID=1, stay RUN. A simultaneous lu_hit is ignored.
//    - else lu_hit: PC_Write=0, IF_buffer_Write=0, NOP=1 (bubble 1).
//      If LOAD_LAT>1: bcnt<=LOAD_LAT-1, next LU_STALL. Otherwise stay RUN.
//  - LU_STALL: PC_Write=0, IF_buffer_Write=0, NOP=1. bcnt<=bcnt-1; when bcnt==1, next RUN.
//    Total bubbles per hazard = LOAD_LAT exactly.
//    - mem_wait here: freeze instead (NOP=0, bcnt held), ret=LU_STALL, next MEM_WAIT.
//    - branch_taken_EX here: flush_IF=flush_ID=1, NOP=0, stall aborted, next RUN.
//  - MEM_WAIT: pipe_freeze=1, PC_Write=0, IF_buffer_Write=0, NOP=0, flush_*=0.
//    Branch and load-use inputs are ignored because the pipe is frozen.
//    When mem_ready=1 the freeze is still asserted that cycle; next state is ret.
//    Back-to-back waits re-enter MEM_WAIT from ret on the following cycle.
//  - Counters: each cycle with its condition, counter += 1, saturating at all-ones (no wrap).
//    clr_cnt zeroes them and takes priority over increment in that cycle.
//    FSM behaviour is unaffected by clr_cnt.
// TESTING
//  1. LOAD_LAT=1: ld x5 in EX, ID reads x5 on rs2 -> 1 cycle NOP=1, PC_Write=0;
//     stall_cycles=1.
//  2. LOAD_LAT=3, same hazard -> NOP=1 for exactly 3 cycles; stall_state 0,1,1,0.
//     Repeat with rd_EX=0, or with rs2_used_ID=0 -> no stall.
//  3. mem_req_MEM=1, mem_ready=0 for 4 cycles, asserted during LU_STALL with bcnt=2
//     -> 5 freeze cycles; resume to LU_STALL with bcnt=2; total bubbles still 3.
//  4. branch_taken_EX=1 together with lu_hit in RUN -> flush_IF=flush_ID=1, NOP=0;
//     flush_count=1. With mem_wait also high -> freeze only, no flush.
//  5. Preload stall_cycles=2^CNT_W-2 (CNT_W=4) and stall 3 cycles -> saturates at 15.
//     clr_cnt=1 -> 0 next cycle.
//  6. rst=1 asserted mid-LU_STALL and mid-MEM_WAIT -> next cycle stall_state=0,
//     default outputs, counters=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls with configurable bubble count,
// data-memory wait freeze, taken-branch flush and saturating perf counters.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              rs1_used_ID,
    input  logic              rs2_used_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              MemRead_EX,
    input  logic              mem_req_MEM,
    input  logic              mem_ready,
    input  logic              branch_taken_EX,
    input  logic              clr_cnt,
    output logic              PC_Write,
    output logic              IF_buffer_Write,
    output logic              NOP,
    output logic              flush_IF,
    output logic              flush_ID,
    output logic              pipe_freeze,
    output logic [1:0]        stall_state,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  freeze_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]       BCNT_INIT = 4'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t     state, state_nx;
    state_t     ret, ret_nx;
    logic [3:0] bcnt, bcnt_nx;
    logic       lu_hit, mem_wait;

    assign lu_hit = MemRead_EX && (rd_EX != '0) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));
    assign mem_wait    = mem_req_MEM && !mem_ready;
    assign stall_state = state;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the case statement can infer a latch.
        PC_Write        = 1'b1;
        IF_buffer_Write = 1'b1;
        NOP             = 1'b0;
        flush_IF        = 1'b0;
        flush_ID        = 1'b0;
        pipe_freeze     = 1'b0;
        state_nx        = state;
        ret_nx          = ret;
        bcnt_nx         = bcnt;

        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        pipe_freeze     = 1'b1;
                        PC_Write        = 1'b0;
                        IF_buffer_Write = 1'b0;
                        ret_nx          = RUN;
                        state_nx        = MEM_WAIT;
                    end else if (branch_taken_EX) begin
                        flush_IF = 1'b1;
                        flush_ID = 1'b1;
                    end else if (lu_hit) begin
                        PC_Write        = 1'b0;
                        IF_buffer_Write = 1'b0;
                        NOP             = 1'b1;
                        if (LOAD_LAT > 1) begin
                            bcnt_nx  = BCNT_INIT;
                            state_nx = LU_STALL;
                        end
                    end
                end
                LU_STALL: begin
                    PC_Write        = 1'b0;
                    IF_buffer_Write = 1'b0;
                    if (mem_wait) begin
                        // Freeze holds bcnt so the remaining bubbles resume afterwards.
                        pipe_freeze = 1'b1;
                        ret_nx      = LU_STALL;
                        state_nx    = MEM_WAIT;
                    end else if (branch_taken_EX) begin
                        PC_Write        = 1'b1;
                        IF_buffer_Write = 1'b1;
                        flush_IF        = 1'b1;
                        flush_ID        = 1'b1;
                        bcnt_nx         = '0;
                        state_nx        = RUN;
                    end else begin
                        NOP     = 1'b1;
                        bcnt_nx = bcnt - 4'd1;
                        if (bcnt == 4'd1) state_nx = RUN;
                    end
                end
                MEM_WAIT: begin
                    pipe_freeze     = 1'b1;
                    PC_Write        = 1'b0;
                    IF_buffer_Write = 1'b0;
                    if (mem_ready) state_nx = ret;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            ret   <= RUN;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            ret   <= ret_nx;
            bcnt  <= bcnt_nx;
        end
    end

    // Counters saturate at all-ones; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
            flush_count   <= '0;
        end else begin
            if (NOP && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_ONE;
            if (pipe_freeze && (freeze_cycles != '1))
                freeze_cycles <= freeze_cycles + CNT_ONE;
            if (flush_IF && (flush_count != '1))
                flush_count <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two hazard_ctrl instances (LOAD_LAT=1/CNT_W=8 and
// LOAD_LAT=3/CNT_W=4) share stimulus and are compared against a bubble-count model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd_ex;
    logic       u1, u2, mem_read, mem_req, mem_ready, br, clr;

    logic       a_pcw, a_ifw, a_nop, a_fi, a_fd, a_frz;
    logic [1:0] a_st;
    logic [7:0] a_stall, a_freeze, a_flush;
    logic       b_pcw, b_ifw, b_nop, b_fi, b_fd, b_frz;
    logic [1:0] b_st;
    logic [3:0] b_stall, b_freeze, b_flush;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining bubbles, freeze flag, bubbles saved across a freeze.
    int     pend[2];
    bit     frozen[2];
    int     saved[2];
    longint c_stall[2], c_freeze[2], c_flush[2];
    int     lat[2]  = '{1, 3};
    longint cmax[2] = '{255, 15};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .rs1_ID(rs1), .rs2_ID(rs2),
        .rs1_used_ID(u1), .rs2_used_ID(u2), .rd_EX(rd_ex), .MemRead_EX(mem_read),
        .mem_req_MEM(mem_req), .mem_ready(mem_ready), .branch_taken_EX(br),
        .clr_cnt(clr), .PC_Write(a_pcw), .IF_buffer_Write(a_ifw), .NOP(a_nop),
        .flush_IF(a_fi), .flush_ID(a_fd), .pipe_freeze(a_frz), .stall_state(a_st),
        .stall_cycles(a_stall), .freeze_cycles(a_freeze), .flush_count(a_flush)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs1_ID(rs1), .rs2_ID(rs2),
        .rs1_used_ID(u1), .rs2_used_ID(u2), .rd_EX(rd_ex), .MemRead_EX(mem_read),
        .mem_req_MEM(mem_req), .mem_ready(mem_ready), .branch_taken_EX(br),
        .clr_cnt(clr), .PC_Write(b_pcw), .IF_buffer_Write(b_ifw), .NOP(b_nop),
        .flush_IF(b_fi), .flush_ID(b_fd), .pipe_freeze(b_frz), .stall_state(b_st),
        .stall_cycles(b_stall), .freeze_cycles(b_freeze), .flush_count(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rs1 = '0; rs2 = '0; rd_ex = '0; u1 = 1'b0; u2 = 1'b0;
        mem_read = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; br = 1'b0; clr = 1'b0;
    endtask

    task automatic hazard();
        mem_read = 1'b1; rd_ex = 5'd5; rs2 = 5'd5; u2 = 1'b1; rs1 = 5'd7; u1 = 1'b1;
    endtask

    // Checks one cycle against the model, then advances to the next negedge.
    task automatic step(input string tag);
        logic [31:0] o[2][10];
        logic [31:0] e[10];
        string       nm[10] = '{"pcw", "ifw", "nop", "fli", "fld", "frz", "st",
                                "cstall", "cfreeze", "cflush"};
        bit lu, mw;
        #1;
        lu = mem_read && (rd_ex != 0) && ((u1 && rs1 == rd_ex) || (u2 && rs2 == rd_ex));
        mw = mem_req && !mem_ready;
        o[0] = '{32'(a_pcw), 32'(a_ifw), 32'(a_nop), 32'(a_fi), 32'(a_fd), 32'(a_frz),
                 32'(a_st), 32'(a_stall), 32'(a_freeze), 32'(a_flush)};
        o[1] = '{32'(b_pcw), 32'(b_ifw), 32'(b_nop), 32'(b_fi), 32'(b_fd), 32'(b_frz),
                 32'(b_st), 32'(b_stall), 32'(b_freeze), 32'(b_flush)};
        for (int k = 0; k < 2; k++) begin
            e = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
            e[6] = frozen[k] ? 2 : (pend[k] > 0 ? 1 : 0);
            e[7] = 32'(c_stall[k]); e[8] = 32'(c_freeze[k]); e[9] = 32'(c_flush[k]);
            if (rst) begin
                pend[k] = 0; frozen[k] = 0; saved[k] = 0;
            end else if (frozen[k]) begin
                e[0] = 0; e[1] = 0; e[5] = 1;
                if (mem_ready) begin frozen[k] = 0; pend[k] = saved[k]; end
            end else if (mw) begin
                e[0] = 0; e[1] = 0; e[5] = 1;
                saved[k] = pend[k]; frozen[k] = 1;
            end else if (br) begin
                e[3] = 1; e[4] = 1; pend[k] = 0;
            end else if (pend[k] > 0) begin
                e[0] = 0; e[1] = 0; e[2] = 1; pend[k]--;
            end else if (lu) begin
                e[0] = 0; e[1] = 0; e[2] = 1; pend[k] = lat[k] - 1;
            end
            for (int i = 0; i < 10; i++)
                if (!(rst && i == 6))
                    check($sformatf("%s.%s.%0d", tag, nm[i], k), o[k][i], e[i]);
            if (rst || clr) begin
                c_stall[k] = 0; c_freeze[k] = 0; c_flush[k] = 0;
            end else begin
                if (e[2] == 1 && c_stall[k] < cmax[k]) c_stall[k]++;
                if (e[5] == 1 && c_freeze[k] < cmax[k]) c_freeze[k]++;
                if (e[3] == 1 && c_flush[k] < cmax[k]) c_flush[k]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; frozen[k] = 0; saved[k] = 0;
            c_stall[k] = 0; c_freeze[k] = 0; c_flush[k] = 0;
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        step("reset");
        idle();
        step("post_reset");

        // Load-use hazard on rs2: one bubble in A, three in B.
        hazard(); step("t1_hit");
        idle();   step("t1_after");
        check("t1_stall_a", 32'(a_stall), 32'd1);
        for (int i = 0; i < 3; i++) step("t2_drain");
        check("t2_stall_b", 32'(b_stall), 32'd3);

        // No stall when rd_EX is x0 or the matching source is unused.
        hazard(); rd_ex = 5'd0; rs2 = 5'd0; step("t2_x0");
        hazard(); u2 = 1'b0;                step("t2_unused");
        idle(); step("t2_idle");

        // Freeze arriving mid-stall in B.
        hazard(); step("t3_hit");
        idle(); mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step("t3_wait");
        mem_ready = 1'b1; step("t3_ready");
        idle();
        for (int i = 0; i < 3; i++) step("t3_resume");

        // Branch beats load-use; memory wait beats branch.
        hazard(); br = 1'b1; step("t4_branch");
        hazard(); br = 1'b1; mem_req = 1'b1; step("t4_freeze");
        idle(); mem_req = 1'b1; mem_ready = 1'b1; step("t4_release");
        idle(); step("t4_idle");

        // Saturation of B's 4-bit stall counter, then clear.
        hazard();
        for (int i = 0; i < 20; i++) step("t5_stall");
        idle();
        for (int i = 0; i < 3; i++) step("t5_drain");
        check("t5_sat_b", 32'(b_stall), 32'd15);
        clr = 1'b1; step("t5_clr");
        clr = 1'b0;
        check("t5_clr_b", 32'(b_stall), 32'd0);
        step("t5_idle");

        // Reset mid-stall and mid-freeze.
        hazard(); step("t6_hit");
        idle(); rst = 1'b1; step("t6_rst_stall");
        rst = 1'b0;
        check("t6_state_b", 32'(b_st), 32'd0);
        mem_req = 1'b1; step("t6_wait");
        step("t6_wait2");
        rst = 1'b1; step("t6_rst_wait");
        idle();
        check("t6_state_a", 32'(a_st), 32'd0);
        check("t6_freeze_a", 32'(a_freeze), 32'd0);
        step("t6_idle");

        // Randomized traffic with narrow register indices to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            clr       = ($urandom_range(0, 49) == 0);
            mem_req   = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            br        = ($urandom_range(0, 7) == 0);
            mem_read  = 1'($urandom_range(0, 1));
            rd_ex     = 5'($urandom_range(0, 3));
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            u1        = 1'($urandom_range(0, 1));
            u2        = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
